// File: rtl/ff_wr_arbiter.sv
// ff_wr_arbiter: two-channel FIFO-buffered round-robin arbiter feeding two register write ports.
// Define FF_WR_ARBITER_STATS_EN to add per-channel grant counters with synchronous clear.
module ff_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req1_valid_i,
  output logic req1_ready_o,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  input  logic req2_valid_i,
  output logic req2_ready_o,
  input  logic [DATA_WIDTH-1:0] req2_data_i,
  output logic write1_en_o,
  output logic write2_en_o,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o,
`ifdef FF_WR_ARBITER_STATS_EN
  input  logic cnt_clr_i,
  output logic [15:0] grant1_cnt_o,
  output logic [15:0] grant2_cnt_o,
`endif
  output logic busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [1:0] vld, rdy, psh, pop, ne;
  logic [DATA_WIDTH-1:0] din [2];
  logic [DATA_WIDTH-1:0] head [2];
  logic last2;
  assign vld = {req2_valid_i, req1_valid_i};
  assign din[0] = req1_data_i;
  assign din[1] = req2_data_i;
  assign req1_ready_o = rdy[0];
  assign req2_ready_o = rdy[1];
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    assign rdy[c] = cnt != CW'(DEPTH);
    assign ne[c] = cnt != '0;
    assign psh[c] = vld[c] & rdy[c];
    assign head[c] = mem[rp];
    always_ff @(posedge clk)
      if (psh[c]) mem[wp] <= din[c];
    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (psh[c]) wp <= wp + 1'b1;
        if (pop[c]) rp <= rp + 1'b1;
        cnt <= cnt + CW'(psh[c]) - CW'(pop[c]);
      end
  end
  // last2 set means channel 2 was granted most recently, so channel 1 wins a tie.
  assign pop[0] = ne[0] & (~ne[1] | last2);
  assign pop[1] = ne[1] & ~pop[0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last2 <= 1'b1;
      write1_en_o <= 1'b0;
      write2_en_o <= 1'b0;
      data1_o <= '0;
      data2_o <= '0;
    end else begin
      if (|pop) last2 <= pop[1];
      write1_en_o <= pop[0];
      write2_en_o <= pop[1];
      if (pop[0]) data1_o <= head[0];
      if (pop[1]) data2_o <= head[1];
    end
  assign busy_o = |ne | write1_en_o | write2_en_o;
`ifdef FF_WR_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      grant1_cnt_o <= '0;
      grant2_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      grant1_cnt_o <= '0;
      grant2_cnt_o <= '0;
    end else begin
      if (write1_en_o && grant1_cnt_o != 16'hFFFF) grant1_cnt_o <= grant1_cnt_o + 1'b1;
      if (write2_en_o && grant2_cnt_o != 16'hFFFF) grant2_cnt_o <= grant2_cnt_o + 1'b1;
    end
`endif
endmodule
